// File: rtl/retire_trace_buffer.sv
// Retire trace FIFO: captures retired instructions from WB, drains to a trace consumer, halts after a halt retire.
// Optional data-memory fields per entry are enabled with the RETIRE_TRACE_DMEM_EN macro.
module retire_trace_buffer #(
    parameter int DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_retire_valid,
    input  logic [31:0] i_retire_pc,
    input  logic [31:0] i_retire_inst,
    input  logic [4:0]  i_retire_rd_waddr,
    input  logic [31:0] i_retire_rd_wdata,
    input  logic        i_retire_trap,
    input  logic        i_retire_halt,
`ifdef RETIRE_TRACE_DMEM_EN
    input  logic [31:0] i_retire_dmem_addr,
    input  logic        i_retire_dmem_ren,
    input  logic        i_retire_dmem_wen,
    input  logic [31:0] i_retire_dmem_wdata,
    output logic [31:0] o_trace_dmem_addr,
    output logic        o_trace_dmem_ren,
    output logic        o_trace_dmem_wen,
    output logic [31:0] o_trace_dmem_wdata,
`endif
    output logic        o_trace_valid,
    input  logic        i_trace_ready,
    output logic [31:0] o_trace_pc,
    output logic [31:0] o_trace_inst,
    output logic [31:0] o_trace_rd_data,
    output logic [4:0]  o_trace_rd,
    output logic [1:0]  o_trace_flags,
    output logic [$clog2(DEPTH):0] o_count,
    output logic [1:0]  o_state,
    output logic        o_halted,
    output logic        o_overflow,
    output logic [31:0] o_retire_count,
    output logic [15:0] o_drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [31:0] rd_data;
        logic        trap;
        logic        halt;
`ifdef RETIRE_TRACE_DMEM_EN
        logic [31:0] dmem_addr;
        logic        dmem_ren;
        logic        dmem_wen;
        logic [31:0] dmem_wdata;
`endif
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          wr_entry;
    entry_t          head;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [31:0]     retire_count_q, retire_count_d;
    logic [15:0]     drop_count_q, drop_count_d;

    logic            full, in_run, push, pop, drop;

    always_comb begin
        wr_entry         = '0;
        wr_entry.pc      = i_retire_pc;
        wr_entry.inst    = i_retire_inst;
        wr_entry.rd      = i_retire_rd_waddr;
        wr_entry.rd_data = i_retire_rd_wdata;
        wr_entry.trap    = i_retire_trap;
        wr_entry.halt    = i_retire_halt;
`ifdef RETIRE_TRACE_DMEM_EN
        wr_entry.dmem_addr  = i_retire_dmem_addr;
        wr_entry.dmem_ren   = i_retire_dmem_ren;
        wr_entry.dmem_wen   = i_retire_dmem_wen;
        wr_entry.dmem_wdata = i_retire_dmem_wdata;
`endif
    end

    always_comb begin
        full   = (count_q == CW'(DEPTH));
        in_run = (state_q == RUN);
        pop    = (count_q != '0) && i_trace_ready;
        // A full FIFO still accepts a retire when the head leaves in the same cycle.
        push   = i_retire_valid && in_run && (!full || pop);
        drop   = i_retire_valid && in_run && full && !pop;

        wr_ptr_d       = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d       = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d        = count_q + CW'(push) - CW'(pop);
        overflow_d     = overflow_q | drop;
        retire_count_d = retire_count_q + 32'(i_retire_valid && in_run);
        drop_count_d   = (drop && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;

        state_d = state_q;
        case (state_q)
            RUN:     if (i_retire_valid && i_retire_halt) state_d = DRAIN;
            DRAIN:   if (count_q == '0) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= RUN;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            retire_count_q <= '0;
            drop_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            overflow_q     <= overflow_d;
            retire_count_q <= retire_count_d;
            drop_count_q   <= drop_count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr_q] <= wr_entry;
    end

    assign head            = mem[rd_ptr_q];
    assign o_trace_valid   = (count_q != '0);
    assign o_trace_pc      = head.pc;
    assign o_trace_inst    = head.inst;
    assign o_trace_rd      = head.rd;
    assign o_trace_rd_data = head.rd_data;
    assign o_trace_flags   = {head.trap, head.halt};
`ifdef RETIRE_TRACE_DMEM_EN
    assign o_trace_dmem_addr  = head.dmem_addr;
    assign o_trace_dmem_ren   = head.dmem_ren;
    assign o_trace_dmem_wen   = head.dmem_wen;
    assign o_trace_dmem_wdata = head.dmem_wdata;
`endif
    assign o_count         = count_q;
    assign o_state         = state_q;
    assign o_halted        = (state_q == HALTED);
    assign o_overflow      = overflow_q;
    assign o_retire_count  = retire_count_q;
    assign o_drop_count    = drop_count_q;
endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer at DEPTH=8: FWFT latency, overflow, full pass-through, halt drain, reset.
module tb_retire_trace_buffer;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_retire_valid;
    logic [31:0] i_retire_pc;
    logic [31:0] i_retire_inst;
    logic [4:0]  i_retire_rd_waddr;
    logic [31:0] i_retire_rd_wdata;
    logic        i_retire_trap;
    logic        i_retire_halt;
    logic        o_trace_valid;
    logic        i_trace_ready;
    logic [31:0] o_trace_pc, o_trace_inst, o_trace_rd_data;
    logic [4:0]  o_trace_rd;
    logic [1:0]  o_trace_flags;
    logic [3:0]  o_count;
    logic [1:0]  o_state;
    logic        o_halted, o_overflow;
    logic [31:0] o_retire_count;
    logic [15:0] o_drop_count;
`ifdef RETIRE_TRACE_DMEM_EN
    logic [31:0] i_retire_dmem_addr, i_retire_dmem_wdata, o_trace_dmem_addr, o_trace_dmem_wdata;
    logic        i_retire_dmem_ren, i_retire_dmem_wen, o_trace_dmem_ren, o_trace_dmem_wen;
`endif

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    retire_trace_buffer #(.DEPTH(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_retire_valid(i_retire_valid), .i_retire_pc(i_retire_pc),
        .i_retire_inst(i_retire_inst), .i_retire_rd_waddr(i_retire_rd_waddr),
        .i_retire_rd_wdata(i_retire_rd_wdata), .i_retire_trap(i_retire_trap),
        .i_retire_halt(i_retire_halt),
`ifdef RETIRE_TRACE_DMEM_EN
        .i_retire_dmem_addr(i_retire_dmem_addr), .i_retire_dmem_ren(i_retire_dmem_ren),
        .i_retire_dmem_wen(i_retire_dmem_wen), .i_retire_dmem_wdata(i_retire_dmem_wdata),
        .o_trace_dmem_addr(o_trace_dmem_addr), .o_trace_dmem_ren(o_trace_dmem_ren),
        .o_trace_dmem_wen(o_trace_dmem_wen), .o_trace_dmem_wdata(o_trace_dmem_wdata),
`endif
        .o_trace_valid(o_trace_valid), .i_trace_ready(i_trace_ready),
        .o_trace_pc(o_trace_pc), .o_trace_inst(o_trace_inst),
        .o_trace_rd_data(o_trace_rd_data), .o_trace_rd(o_trace_rd),
        .o_trace_flags(o_trace_flags), .o_count(o_count), .o_state(o_state),
        .o_halted(o_halted), .o_overflow(o_overflow),
        .o_retire_count(o_retire_count), .o_drop_count(o_drop_count)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_retire(input logic v, input logic [31:0] pc, input logic halt);
        i_retire_valid    = v;
        i_retire_pc       = pc;
        i_retire_inst     = pc ^ 32'h0000_0013;
        i_retire_rd_waddr = pc[6:2];
        i_retire_rd_wdata = ~pc;
        i_retire_trap     = 1'b0;
        i_retire_halt     = halt;
`ifdef RETIRE_TRACE_DMEM_EN
        i_retire_dmem_addr  = 32'h0;
        i_retire_dmem_ren   = 1'b0;
        i_retire_dmem_wen   = 1'b0;
        i_retire_dmem_wdata = 32'h0;
`endif
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        set_retire(1'b0, 32'h0, 1'b0);
        i_trace_ready = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 7;
        if (o_trace_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", o_trace_valid); end
        if (o_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", o_count); end
        if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", o_state); end
        if (o_halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b want 0", o_halted); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", o_overflow); end
        if (o_retire_count !== 32'd0) begin errors++; $display("FAIL reset_retire_count: got %0d want 0", o_retire_count); end
        if (o_drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count: got %0d want 0", o_drop_count); end
    endtask

    task automatic test_basic();
        logic [31:0] pcs [3];
        pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
        do_reset();
        i_trace_ready = 1'b1;
        // No bypass: while empty, the head must not show the retire being presented.
        set_retire(1'b1, pcs[0], 1'b0);
        #1;
        checks++;
        if (o_trace_valid !== 1'b0) begin errors++; $display("FAIL basic_no_bypass: got %0b want 0", o_trace_valid); end
        for (int i = 0; i < 3; i++) begin
            set_retire(1'b1, pcs[i], 1'b0);
            tick();
            checks += 5;
            if (o_trace_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %0b want 1", i, o_trace_valid); end
            if (o_trace_pc !== pcs[i]) begin errors++; $display("FAIL basic_pc[%0d]: got %h want %h", i, o_trace_pc, pcs[i]); end
            if (o_trace_inst !== (pcs[i] ^ 32'h13)) begin errors++; $display("FAIL basic_inst[%0d]: got %h want %h", i, o_trace_inst, pcs[i] ^ 32'h13); end
            if (o_trace_rd_data !== ~pcs[i]) begin errors++; $display("FAIL basic_rd_data[%0d]: got %h want %h", i, o_trace_rd_data, ~pcs[i]); end
            if (o_count !== 4'd1) begin errors++; $display("FAIL basic_count[%0d]: got %0d want 1", i, o_count); end
        end
        set_retire(1'b0, 32'h0, 1'b0);
        tick();
        checks += 4;
        if (o_trace_valid !== 1'b0) begin errors++; $display("FAIL basic_empty: got %0b want 0", o_trace_valid); end
        if (o_retire_count !== 32'd3) begin errors++; $display("FAIL basic_retire_count: got %0d want 3", o_retire_count); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %0b want 0", o_overflow); end
        tick();
        if (o_count !== 4'd0) begin errors++; $display("FAIL basic_pop_empty: got %0d want 0", o_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_retire(1'b1, 32'h100 + 32'(4 * i), 1'b0);
            tick();
        end
        set_retire(1'b0, 32'h0, 1'b0);
        checks += 4;
        if (o_count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d want 8", o_count); end
        if (o_drop_count !== 16'd2) begin errors++; $display("FAIL ovf_drop_count: got %0d want 2", o_drop_count); end
        if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", o_overflow); end
        if (o_retire_count !== 32'd10) begin errors++; $display("FAIL ovf_retire_count: got %0d want 10", o_retire_count); end
        i_trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (o_trace_pc !== 32'h100 + 32'(4 * i)) begin errors++; $display("FAIL ovf_drain_pc[%0d]: got %h want %h", i, o_trace_pc, 32'h100 + 32'(4 * i)); end
            tick();
        end
        checks += 2;
        if (o_trace_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %0b want 0", o_trace_valid); end
        if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", o_overflow); end
    endtask

    task automatic test_full_passthrough();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_retire(1'b1, 32'h200 + 32'(4 * i), 1'b0);
            tick();
        end
        i_trace_ready = 1'b1;
        for (int j = 0; j < 20; j++) begin
            set_retire(1'b1, 32'h200 + 32'(4 * (8 + j)), 1'b0);
            checks++;
            if (o_trace_pc !== 32'h200 + 32'(4 * j)) begin errors++; $display("FAIL full_head[%0d]: got %h want %h", j, o_trace_pc, 32'h200 + 32'(4 * j)); end
            tick();
            checks++;
            if (o_count !== 4'd8) begin errors++; $display("FAIL full_count[%0d]: got %0d want 8", j, o_count); end
        end
        set_retire(1'b0, 32'h0, 1'b0);
        checks += 3;
        if (o_drop_count !== 16'd0) begin errors++; $display("FAIL full_drop: got %0d want 0", o_drop_count); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL full_overflow: got %0b want 0", o_overflow); end
        if (o_retire_count !== 32'd28) begin errors++; $display("FAIL full_retire_count: got %0d want 28", o_retire_count); end
        for (int j = 20; j < 28; j++) begin
            checks++;
            if (o_trace_pc !== 32'h200 + 32'(4 * j)) begin errors++; $display("FAIL full_drain[%0d]: got %h want %h", j, o_trace_pc, 32'h200 + 32'(4 * j)); end
            tick();
        end
    endtask

    task automatic fill_and_halt();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_retire(1'b1, 32'h10 + 32'(4 * i), 1'b0);
            tick();
        end
        set_retire(1'b1, 32'h40, 1'b1);
        tick();
    endtask

    task automatic test_halt_drain();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h10; exp_pc[1] = 32'h14; exp_pc[2] = 32'h18; exp_pc[3] = 32'h40;
        fill_and_halt();
        checks += 2;
        if (o_state !== 2'd1) begin errors++; $display("FAIL halt_state_drain: got %0d want 1", o_state); end
        if (o_count !== 4'd4) begin errors++; $display("FAIL halt_count: got %0d want 4", o_count); end
        for (int i = 0; i < 2; i++) begin
            set_retire(1'b1, 32'h44 + 32'(4 * i), 1'b0);
            tick();
        end
        set_retire(1'b0, 32'h0, 1'b0);
        checks += 2;
        if (o_count !== 4'd4) begin errors++; $display("FAIL halt_ignored_count: got %0d want 4", o_count); end
        if (o_retire_count !== 32'd4) begin errors++; $display("FAIL halt_ignored_retires: got %0d want 4", o_retire_count); end
        i_trace_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks += 2;
            if (o_trace_pc !== exp_pc[i]) begin errors++; $display("FAIL halt_pop_pc[%0d]: got %h want %h", i, o_trace_pc, exp_pc[i]); end
            if (o_trace_flags !== ((i == 3) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL halt_pop_flags[%0d]: got %b want %b", i, o_trace_flags, (i == 3) ? 2'b01 : 2'b00); end
            tick();
        end
        checks += 2;
        if (o_state !== 2'd1) begin errors++; $display("FAIL halt_still_drain: got %0d want 1", o_state); end
        if (o_halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %0b want 0", o_halted); end
        set_retire(1'b1, 32'h80, 1'b0);
        tick();
        checks += 2;
        if (o_state !== 2'd2) begin errors++; $display("FAIL halt_state_halted: got %0d want 2", o_state); end
        if (o_halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %0b want 1", o_halted); end
        tick();
        set_retire(1'b0, 32'h0, 1'b0);
        checks += 3;
        if (o_count !== 4'd0) begin errors++; $display("FAIL halted_ignored_count: got %0d want 0", o_count); end
        if (o_retire_count !== 32'd4) begin errors++; $display("FAIL halted_ignored_retires: got %0d want 4", o_retire_count); end
        if (o_state !== 2'd2) begin errors++; $display("FAIL halted_persist: got %0d want 2", o_state); end
    endtask

    task automatic test_reset_in_drain();
        fill_and_halt();
        checks++;
        if (o_count !== 4'd4) begin errors++; $display("FAIL rst_drain_setup: got %0d want 4", o_count); end
        // Reset wins over a concurrent push and pop.
        i_rst = 1'b1;
        i_trace_ready = 1'b1;
        set_retire(1'b1, 32'h90, 1'b0);
        tick();
        i_rst = 1'b0;
        set_retire(1'b0, 32'h0, 1'b0);
        checks += 6;
        if (o_count !== 4'd0) begin errors++; $display("FAIL rst_drain_count: got %0d want 0", o_count); end
        if (o_trace_valid !== 1'b0) begin errors++; $display("FAIL rst_drain_valid: got %0b want 0", o_trace_valid); end
        if (o_state !== 2'd0) begin errors++; $display("FAIL rst_drain_state: got %0d want 0", o_state); end
        if (o_retire_count !== 32'd0) begin errors++; $display("FAIL rst_drain_retires: got %0d want 0", o_retire_count); end
        if (o_drop_count !== 16'd0) begin errors++; $display("FAIL rst_drain_drops: got %0d want 0", o_drop_count); end
        if (o_overflow !== 1'b0) begin errors++; $display("FAIL rst_drain_overflow: got %0b want 0", o_overflow); end
    endtask

`ifdef RETIRE_TRACE_DMEM_EN
    task automatic test_dmem();
        do_reset();
        set_retire(1'b1, 32'h50, 1'b0);
        i_retire_dmem_addr  = 32'h100;
        i_retire_dmem_wdata = 32'hDEADBEEF;
        i_retire_dmem_wen   = 1'b1;
        i_retire_dmem_ren   = 1'b0;
        tick();
        set_retire(1'b0, 32'h0, 1'b0);
        checks += 4;
        if (o_trace_dmem_addr !== 32'h100) begin errors++; $display("FAIL dmem_addr: got %h want 00000100", o_trace_dmem_addr); end
        if (o_trace_dmem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL dmem_wdata: got %h want deadbeef", o_trace_dmem_wdata); end
        if (o_trace_dmem_wen !== 1'b1) begin errors++; $display("FAIL dmem_wen: got %0b want 1", o_trace_dmem_wen); end
        if (o_trace_dmem_ren !== 1'b0) begin errors++; $display("FAIL dmem_ren: got %0b want 0", o_trace_dmem_ren); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_passthrough();
        test_halt_drain();
        test_reset_in_drain();
`ifdef RETIRE_TRACE_DMEM_EN
        test_dmem();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
